// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the run-control sequencer: FSM states and halt reason codes.
package cpu_run_ctrl_pkg;

  localparam int PC_W = 30;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_CALIB = 3'd1,
    ST_RUN        = 3'd2,
    ST_STEP       = 3'd3,
    ST_DRAIN      = 3'd4
  } run_state_e;

  typedef enum logic [2:0] {
    HR_NONE       = 3'd0,
    HR_STOP       = 3'd1,
    HR_STEP_DONE  = 3'd2,
    HR_BREAK      = 3'd3,
    HR_CALIB_LOST = 3'd4
  } halt_reason_e;

endpackage

// File: rtl/cpu_run_ctrl_step_counter.sv
// Step budget counter: loads a cycle count, decrements on enable, saturates at zero.
module run_step_counter
  import cpu_run_ctrl_pkg::*;
#(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [STEP_W-1:0] load_val,
  input  logic              dec_en,
  output logic [STEP_W-1:0] count,
  output logic              zero,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  // last marks the decrement that empties the budget, so the halt can be issued on that edge
  assign last = (count == STEP_W'(1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: host start/stop/step commands to cpu_start/quit_cmd pulses.
// Define RUN_CTRL_BREAKPOINT_EN to enable the PC breakpoint halt.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int STEP_W       = 16,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              stall,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              cmd_step,
  input  logic [STEP_W-1:0] step_count,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   pc_id,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic              running,
  output logic              busy,
  output logic              cmd_err,
  output logic [2:0]        halt_reason,
  output logic [STEP_W-1:0] step_remain,
  output logic [2:0]        state_dbg
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  run_state_e         state, state_d;
  halt_reason_e       halt_q, halt_d, halt_why;
  logic               mode_step, mode_step_d;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_d;
  logic               cpu_start_d, quit_cmd_d, cmd_err_d, running_d, busy_d;
  logic               halt_hit, step_done, bp_hit;
  logic               cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic               idle_go, idle_go_step, idle_err;

  // Commands are single-cycle pulses with no back-pressure: each is either accepted
  // or answered by a cmd_err pulse the next cycle; cmd_stop in IDLE suppresses both.
  assign idle_go_step = ~cmd_stop & cmd_step & ~cmd_start & (step_count != '0);
  assign idle_go      = idle_go_step | (~cmd_stop & cmd_start & ~cmd_step);
  assign idle_err     = ~cmd_stop & cmd_step & (cmd_start | (step_count == '0));

  assign cnt_load = (state == ST_IDLE) & idle_go_step;
  assign cnt_dec  = (state == ST_STEP) & ~cpu_start & ~stall;

  run_step_counter #(.STEP_W(STEP_W)) u_step_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (step_count),
    .dec_en   (cnt_dec),
    .count    (step_remain),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic cpu_start_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_start_q <= 1'b0;
    else        cpu_start_q <= cpu_start;
  end
  // Masked for two cycles after cpu_start so a resume from the breakpoint PC gets going
  assign bp_hit = bp_en & ~stall & (pc_id == bp_addr) & ~cpu_start & ~cpu_start_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc_id};
  assign bp_hit    = 1'b0;
`endif

  assign step_done = (state == ST_STEP) & ((cnt_dec & cnt_last) | cnt_zero);

  always_comb begin
    halt_hit = 1'b1;
    halt_why = HR_NONE;
    if (!init_calib_complete)  halt_why = HR_CALIB_LOST;
    else if (cmd_stop)         halt_why = HR_STOP;
    else if (step_done)        halt_why = HR_STEP_DONE;
    else if (bp_hit)           halt_why = HR_BREAK;
    else                       halt_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_step <= 1'b0;
      drain_cnt <= '0;
      halt_q    <= HR_NONE;
      cpu_start <= 1'b0;
      quit_cmd  <= 1'b0;
      cmd_err   <= 1'b0;
      running   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      mode_step <= mode_step_d;
      drain_cnt <= drain_cnt_d;
      halt_q    <= halt_d;
      cpu_start <= cpu_start_d;
      quit_cmd  <= quit_cmd_d;
      cmd_err   <= cmd_err_d;
      running   <= running_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state;
    mode_step_d = mode_step;
    drain_cnt_d = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (idle_go) begin
          mode_step_d = idle_go_step;
          if (!init_calib_complete) state_d = ST_WAIT_CALIB;
          else                      state_d = idle_go_step ? ST_STEP : ST_RUN;
        end
      end
      ST_WAIT_CALIB: begin
        if (cmd_stop)                 state_d = ST_IDLE;
        else if (init_calib_complete) state_d = mode_step ? ST_STEP : ST_RUN;
      end
      ST_RUN, ST_STEP: begin
        if (halt_hit) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_d = ST_IDLE;
        else                         drain_cnt_d = drain_cnt + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_start_d = 1'b0;
    quit_cmd_d  = 1'b0;
    cmd_err_d   = cmd_start | cmd_step;
    halt_d      = halt_q;
    case (state)
      ST_IDLE: begin
        cmd_err_d = idle_err;
        if (idle_go) begin
          halt_d      = HR_NONE;
          cpu_start_d = init_calib_complete;
        end
      end
      ST_WAIT_CALIB: begin
        if (cmd_stop) halt_d = HR_STOP;
        else          cpu_start_d = init_calib_complete;
      end
      ST_RUN, ST_STEP: begin
        if (halt_hit) begin
          quit_cmd_d = 1'b1;
          halt_d     = halt_why;
        end
      end
      default: ;
    endcase
    running_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    busy_d    = (state_d != ST_IDLE);
  end

  assign halt_reason = halt_q;
  assign state_dbg   = state;

endmodule
